// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding,
// debug-bus width and the one-hot classifier used to grade an accepted press.
package condicionador_botoes_pkg;

    localparam int ESTADO_W = 3;
    localparam int N_BOTOES = 4;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO         = 3'd0,
        FILTRA_PRESSAO = 3'd1,
        PRESSIONADO    = 3'd2,
        FILTRA_SOLTURA = 3'd3
    } estado_t;

    function automatic logic eh_one_hot(input logic [N_BOTOES-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/condicionador_botoes_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; every bit is
// resampled independently, so it is only suited to quasi-static levels.
module sincronizador_2ff #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] dado_i,
    output logic [LARGURA-1:0] dado_o
);

    logic [LARGURA-1:0] meta_q;
    logic [LARGURA-1:0] sinc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sinc_q <= '0;
        end else begin
            meta_q <= dado_i;
            sinc_q <= meta_q;
        end
    end

    assign dado_o = sinc_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: synchronizes four raw buttons, debounces press and
// release, and grades each accepted press as a valid (one-hot) or invalid move.
module condicionador_botoes
    import condicionador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          botoes_raw,
    input  logic                habilita,
    output logic [3:0]          botoes_limpos,
    output logic                jogada_valida,
    output logic                jogada_invalida,
    output logic                ativo,
    output logic [ESTADO_W-1:0] db_estado
);

    localparam int               CONT_W   = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CONT_W-1:0] CONT_MAX = CONT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [CONT_W-1:0] CONT_UM  = CONT_W'(1);

    logic [3:0]        botoes_s;
    estado_t           estado_q, estado_d;
    logic [3:0]        cand_q, cand_d;
    logic [CONT_W-1:0] cont_q, cont_d;
    logic [3:0]        limpos_q, limpos_d;
    logic              valida_q, valida_d;
    logic              invalida_q, invalida_d;

    sincronizador_2ff #(
        .LARGURA (4)
    ) u_sincronizador (
        .clock  (clock),
        .reset  (reset),
        .dado_i (botoes_raw),
        .dado_o (botoes_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            cand_q     <= '0;
            cont_q     <= '0;
            limpos_q   <= '0;
            valida_q   <= 1'b0;
            invalida_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cand_q     <= cand_d;
            cont_q     <= cont_d;
            limpos_q   <= limpos_d;
            valida_q   <= valida_d;
            invalida_q <= invalida_d;
        end
    end

    // Pulses default low so they last exactly the one cycle after the accept edge.
    always_comb begin
        estado_d   = estado_q;
        cand_d     = cand_q;
        cont_d     = cont_q;
        limpos_d   = limpos_q;
        valida_d   = 1'b0;
        invalida_d = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if ((botoes_s != 4'b0000) && habilita) begin
                    cand_d   = botoes_s;
                    cont_d   = '0;
                    estado_d = FILTRA_PRESSAO;
                end
            end

            FILTRA_PRESSAO: begin
                if (!habilita || (botoes_s == 4'b0000)) begin
                    estado_d = OCIOSO;
                end else if (botoes_s != cand_q) begin
                    cand_d = botoes_s;
                    cont_d = '0;
                end else if (cont_q == CONT_MAX) begin
                    estado_d = PRESSIONADO;
                    limpos_d = cand_q;
                    if (eh_one_hot(cand_q)) begin
                        valida_d = 1'b1;
                    end else begin
                        invalida_d = 1'b1;
                    end
                end else begin
                    cont_d = cont_q + CONT_UM;
                end
            end

            // A different nonzero combination while held is deliberately ignored.
            PRESSIONADO: begin
                if (botoes_s == 4'b0000) begin
                    cont_d   = '0;
                    estado_d = FILTRA_SOLTURA;
                end
            end

            FILTRA_SOLTURA: begin
                if (botoes_s != 4'b0000) begin
                    estado_d = PRESSIONADO;
                end else if (cont_q == CONT_MAX) begin
                    limpos_d = '0;
                    estado_d = OCIOSO;
                end else begin
                    cont_d = cont_q + CONT_UM;
                end
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign botoes_limpos   = limpos_q;
    assign jogada_valida   = valida_q;
    assign jogada_invalida = invalida_q;
    assign ativo           = (estado_q != OCIOSO);
    assign db_estado       = estado_q;

    a_pulsos_exclusivos: assert property (
        @(posedge clock) disable iff (!reset) !(jogada_valida && jogada_invalida));

    a_pulsos_nao_consecutivos: assert property (
        @(posedge clock) disable iff (!reset)
        (jogada_valida || jogada_invalida) |=> !(jogada_valida || jogada_invalida));

    a_contador_limite: assert property (
        @(posedge clock) disable iff (!reset) cont_q <= CONT_MAX);

endmodule
